// File: rtl/implication_responder.sv
// Responder for antecedent/consequent implication checks: every accepted request
// matures after LATENCY cycles and is issued as one consequent pulse, buffered while stalled.
module implication_responder #(
   parameter int LATENCY     = 1,
   parameter int MAX_PENDING = 7,
   parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             antecedent,
   input  logic             stall,
   output logic             consequent,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] PENDING_FULL = CNT_W'(MAX_PENDING);

   logic             matured;
   logic [CNT_W-1:0] pending_next;
   logic             overflow_next;

   generate
      if (LATENCY == 0) begin : g_overlap
         // Overlapping relation: a request matures in the cycle it is presented.
         assign matured = antecedent;
      end else begin : g_delay
         logic [LATENCY-1:0] stage;

         always_ff @(posedge clk) begin
            if (rst) begin
               stage <= '0;
            end else begin
               stage[0] <= antecedent;
               for (int i = 1; i < LATENCY; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign matured = stage[LATENCY-1];
      end
   endgenerate

   assign consequent = !rst && !stall && ((pending != '0) || matured);

   // A matured response that cannot be issued is buffered, or dropped once the buffer is full.
   always_comb begin
      pending_next  = pending;
      overflow_next = overflow;
      if (matured && !consequent) begin
         if (pending == PENDING_FULL) begin
            overflow_next = 1'b1;
         end else begin
            pending_next = pending + 1'b1;
         end
      end else if (!matured && consequent) begin
         pending_next = pending - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         pending  <= pending_next;
         overflow <= overflow_next;
      end
   end

endmodule

// File: tb/tb_implication_responder.sv
// Bench for implication_responder: five parameterisations share one stimulus stream and
// are checked against directed expectations and a due-time schedule reference model.
module tb_implication_responder;

   localparam int N = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic antecedent = 1'b0;
   logic stall = 1'b0;

   logic       c0, c1, c2, c3, c4;
   logic [2:0] p0, p1, p2, p4;
   logic [1:0] p3;
   logic       o0, o1, o2, o3, o4;

   int checks = 0;
   int failures = 0;

   int lat[N] = '{1, 0, 2, 1, 3};
   int mx[N]  = '{7, 7, 7, 2, 7};

   // Reference model: each accepted request schedules a response due LATENCY cycles later.
   bit sched[N][16];
   int mpend[N];
   bit movf[N];
   bit mmat[N];
   bit exp_cons[N];
   int cyc = 0;

   bit obs_cons[N];
   int obs_pend[N];
   bit obs_ovf[N];

   always #5 clk = ~clk;

   implication_responder #(.LATENCY(1), .MAX_PENDING(7)) dut0 (
      .clk(clk), .rst(rst), .antecedent(antecedent), .stall(stall),
      .consequent(c0), .pending(p0), .overflow(o0));
   implication_responder #(.LATENCY(0), .MAX_PENDING(7)) dut1 (
      .clk(clk), .rst(rst), .antecedent(antecedent), .stall(stall),
      .consequent(c1), .pending(p1), .overflow(o1));
   implication_responder #(.LATENCY(2), .MAX_PENDING(7)) dut2 (
      .clk(clk), .rst(rst), .antecedent(antecedent), .stall(stall),
      .consequent(c2), .pending(p2), .overflow(o2));
   implication_responder #(.LATENCY(1), .MAX_PENDING(2)) dut3 (
      .clk(clk), .rst(rst), .antecedent(antecedent), .stall(stall),
      .consequent(c3), .pending(p3), .overflow(o3));
   implication_responder #(.LATENCY(3), .MAX_PENDING(7)) dut4 (
      .clk(clk), .rst(rst), .antecedent(antecedent), .stall(stall),
      .consequent(c4), .pending(p4), .overflow(o4));

   // One clock cycle: drive inputs, sample the combinational response mid-cycle,
   // then sample registered state after the edge and advance the model.
   task automatic cycle(input logic r, input logic a, input logic s);
      rst = r;
      antecedent = a;
      stall = s;
      #1;
      obs_cons = '{c0, c1, c2, c3, c4};
      for (int k = 0; k < N; k++) begin
         if (lat[k] == 0) mmat[k] = a && !r;
         else             mmat[k] = sched[k][cyc % 16];
         exp_cons[k] = !r && !s && (mpend[k] > 0 || mmat[k]);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (r) begin
            for (int j = 0; j < 16; j++) sched[k][j] = 1'b0;
            mpend[k] = 0;
            movf[k] = 1'b0;
         end else begin
            if (lat[k] > 0) begin
               sched[k][cyc % 16] = 1'b0;
               if (a) sched[k][(cyc + lat[k]) % 16] = 1'b1;
            end
            if (mmat[k] && !exp_cons[k]) begin
               if (mpend[k] == mx[k]) movf[k] = 1'b1;
               else                   mpend[k] = mpend[k] + 1;
            end else if (exp_cons[k] && !mmat[k]) begin
               mpend[k] = mpend[k] - 1;
            end
         end
      end
      cyc++;
      obs_pend = '{int'(p0), int'(p1), int'(p2), int'(p3), int'(p4)};
      obs_ovf  = '{o0, o1, o2, o3, o4};
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < N; k++) begin
         checks += 3;
         if (obs_cons[k] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_cons dut=%0d got=%0b exp=0", k, obs_cons[k]);
         end
         if (obs_pend[k] !== 0) begin
            failures++;
            $display("[TB] FAIL reset_pend dut=%0d got=%0d exp=0", k, obs_pend[k]);
         end
         if (obs_ovf[k] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ovf dut=%0d got=%0b exp=0", k, obs_ovf[k]);
         end
      end
   endtask

   task automatic test_latency1();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, i == 5, 1'b0);
         checks += 3;
         if (obs_cons[0] !== (i == 6)) begin
            failures++;
            $display("[TB] FAIL lat1_cons i=%0d got=%0b exp=%0b", i, obs_cons[0], i == 6);
         end
         if (obs_pend[0] !== 0) begin
            failures++;
            $display("[TB] FAIL lat1_pend i=%0d got=%0d exp=0", i, obs_pend[0]);
         end
         if (obs_ovf[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lat1_ovf i=%0d got=%0b exp=0", i, obs_ovf[0]);
         end
      end
   endtask

   task automatic test_overlap();
      bit hit;
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         hit = (i == 3) || (i == 4) || (i == 7);
         cycle(1'b0, hit, 1'b0);
         checks += 2;
         if (obs_cons[1] !== hit) begin
            failures++;
            $display("[TB] FAIL lat0_cons i=%0d got=%0b exp=%0b", i, obs_cons[1], hit);
         end
         if (obs_pend[1] !== 0) begin
            failures++;
            $display("[TB] FAIL lat0_pend i=%0d got=%0d exp=0", i, obs_pend[1]);
         end
      end
   endtask

   task automatic test_stall_drain();
      int ep;
      bit ec;
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         cycle(1'b0, i >= 1 && i <= 3, i <= 9);
         if (i < 3)       ep = 0;
         else if (i < 5)  ep = i - 2;
         else if (i < 10) ep = 3;
         else if (i < 13) ep = 12 - i;
         else             ep = 0;
         ec = (i >= 10) && (i <= 12);
         checks += 2;
         if (obs_cons[2] !== ec) begin
            failures++;
            $display("[TB] FAIL stall_cons i=%0d got=%0b exp=%0b", i, obs_cons[2], ec);
         end
         if (obs_pend[2] !== ep) begin
            failures++;
            $display("[TB] FAIL stall_pend i=%0d got=%0d exp=%0d", i, obs_pend[2], ep);
         end
      end
   endtask

   task automatic test_saturation();
      int ep;
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, i <= 3, i <= 5);
         if (i < 2)      ep = i;
         else if (i < 6) ep = 2;
         else if (i < 8) ep = 7 - i;
         else            ep = 0;
         checks += 3;
         if (obs_cons[3] !== (i == 6 || i == 7)) begin
            failures++;
            $display("[TB] FAIL sat_cons i=%0d got=%0b exp=%0b", i, obs_cons[3], i == 6 || i == 7);
         end
         if (obs_pend[3] !== ep) begin
            failures++;
            $display("[TB] FAIL sat_pend i=%0d got=%0d exp=%0d", i, obs_pend[3], ep);
         end
         if (obs_ovf[3] !== (i >= 3)) begin
            failures++;
            $display("[TB] FAIL sat_ovf i=%0d got=%0b exp=%0b", i, obs_ovf[3], i >= 3);
         end
      end
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_ovf[3] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sat_ovf_clear got=%0b exp=0", obs_ovf[3]);
      end
   endtask

   task automatic test_pass_through();
      int ep;
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, i <= 2, i <= 2);
         if (i < 3)      ep = i;
         else if (i < 6) ep = (i == 3) ? 2 : 5 - i;
         else            ep = 0;
         checks += 3;
         if (obs_cons[3] !== (i >= 3 && i <= 5)) begin
            failures++;
            $display("[TB] FAIL pass_cons i=%0d got=%0b exp=%0b", i, obs_cons[3], i >= 3 && i <= 5);
         end
         if (obs_pend[3] !== ep) begin
            failures++;
            $display("[TB] FAIL pass_pend i=%0d got=%0d exp=%0d", i, obs_pend[3], ep);
         end
         if (obs_ovf[3] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pass_ovf i=%0d got=%0b exp=0", i, obs_ovf[3]);
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(i == 2, i == 0 || i == 4, 1'b0);
         checks++;
         if (obs_cons[4] !== (i == 7)) begin
            failures++;
            $display("[TB] FAIL rstmid_cons i=%0d got=%0b exp=%0b", i, obs_cons[4], i == 7);
         end
         if (i == 2) begin
            checks += 2;
            if (obs_pend[4] !== 0) begin
               failures++;
               $display("[TB] FAIL rstmid_pend got=%0d exp=0", obs_pend[4]);
            end
            if (obs_ovf[4] !== 1'b0) begin
               failures++;
               $display("[TB] FAIL rstmid_ovf got=%0b exp=0", obs_ovf[4]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         for (int k = 0; k < N; k++) begin
            checks += 2;
            if (obs_cons[k] !== (i >= lat[k])) begin
               failures++;
               $display("[TB] FAIL b2b_cons dut=%0d i=%0d got=%0b exp=%0b", k, i, obs_cons[k], i >= lat[k]);
            end
            if (obs_pend[k] !== 0) begin
               failures++;
               $display("[TB] FAIL b2b_pend dut=%0d i=%0d got=%0d exp=0", k, i, obs_pend[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic s = 1'b0;
      logic r;
      logic a;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(4) == 0) s = ~s;
         r = ($urandom_range(63) == 0);
         a = $urandom_range(1) == 1;
         cycle(r, a, s);
         for (int k = 0; k < N; k++) begin
            checks += 3;
            if (obs_cons[k] !== exp_cons[k]) begin
               failures++;
               $display("[TB] FAIL rand_cons dut=%0d i=%0d got=%0b exp=%0b", k, i, obs_cons[k], exp_cons[k]);
            end
            if (obs_pend[k] !== mpend[k]) begin
               failures++;
               $display("[TB] FAIL rand_pend dut=%0d i=%0d got=%0d exp=%0d", k, i, obs_pend[k], mpend[k]);
            end
            if (obs_ovf[k] !== movf[k]) begin
               failures++;
               $display("[TB] FAIL rand_ovf dut=%0d i=%0d got=%0b exp=%0b", k, i, obs_ovf[k], movf[k]);
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         mpend[k] = 0;
         movf[k] = 1'b0;
         for (int j = 0; j < 16; j++) sched[k][j] = 1'b0;
      end
      test_reset();
      test_latency1();
      test_overlap();
      test_stall_drain();
      test_saturation();
      test_pass_through();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/implication_responder.md
Name: implication_responder

Overview:
- Responder side of the antecedent/consequent request–response relation.
- Each antecedent pulse is answered with exactly one consequent pulse, nominally LATENCY cycles later.
- LATENCY=0 models the overlapping relation (|->); LATENCY=1 models the non-overlapping relation (|=>).
- Responses held back by stall are buffered as a pending count and drained one per cycle. This makes the block the driven DUT for the implication checkers and for the formal (SBY) flows.

Parameters:
- LATENCY, 1, cycles from antecedent to matured response; legal range 0..8.
- MAX_PENDING, 7, maximum buffered responses; legal range 1..255.
- CNT_W, $clog2(MAX_PENDING+1), width of the pending counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- antecedent  input  1  request; each cycle it is high counts as one request.
- stall  input  1  when high, suppresses consequent; matured responses are buffered.
- consequent  output  1  response pulse; one cycle per answered request.
- pending  output  CNT_W  number of buffered matured responses not yet issued.
- overflow  output  1  sticky; set when a matured response is dropped.

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is sampled synchronously; the cycle after rst is seen high: delay line = 0, pending = 0, overflow = 0.
  - While rst is high, consequent = 0 and antecedent is ignored (not entered into the delay line).
  - Reset mid-operation discards all in-flight and buffered responses; no response is issued for them.
- Delay line:
  - LATENCY>=1: LATENCY-stage shift register; stage 0 <= antecedent; matured = last stage.
  - LATENCY=0: no register; matured = antecedent (same cycle, combinational).
- Output:
  - consequent = !rst && !stall && (pending != 0 || matured); combinational from registered state, matured and stall.
  - Buffered responses are served before a new matured response. Both are single bits, so ordering is not observable beyond the count.
- Counter update, every non-reset cycle:
  - pending_next = pending + matured - consequent.
  - Saturation: if pending == MAX_PENDING && matured && !consequent, then pending stays MAX_PENDING, the response is dropped and overflow <= 1.
  - overflow clears only on rst.
  - pending never wraps below 0: consequent is never high with pending == 0 and matured == 0.
- Simultaneous events:
  - matured && consequent with pending == N: the response passes through and pending stays N; this is not an overflow even when N == MAX_PENDING.
  - stall deasserting: consequent is high in that same cycle if pending != 0 or matured.
  - Back-to-back antecedent (high every cycle) with stall low: consequent high every cycle, delayed by LATENCY; pending stays 0.
- Guaranteed properties (provided as concurrent assertions in the formal harness, gated by !rst):
  - With stall held low and pending == 0: antecedent |-> ##LATENCY consequent.
  - pending <= MAX_PENDING.
  - consequent implies (pending != 0 || matured).
  - $rose(overflow) implies $past(pending) == MAX_PENDING.
- Latency:
  - Unstalled: exactly LATENCY cycles.
  - Stalled: LATENCY plus the stall duration plus queue-drain position.
  - No response is ever issued early.

Test Plan:
- LATENCY=1, stall=0, antecedent pulse at cycle 5 -> consequent high only at cycle 6; pending stays 0; overflow 0.
- LATENCY=0, antecedent high at cycles 3,4,7 -> consequent high at exactly cycles 3,4,7 (same cycle); pending 0 throughout.
- LATENCY=2, stall=1 cycles 0–9, antecedent at cycles 1,2,3 -> pending reads 1,2,3 after cycles 3,4,5; stall drops at cycle 10 -> consequent high cycles 10,11,12, pending 2,1,0 after each.
- MAX_PENDING=2, LATENCY=1, stall=1, antecedent at cycles 0..3 -> pending saturates at 2 after cycle 2; overflow rises after cycle 3; release stall -> exactly 2 consequent pulses; overflow stays 1 until rst.
- Pass-through at full: MAX_PENDING=2, pending=2, stall=0, matured=1 -> consequent high, pending remains 2, overflow stays 0.
- Reset mid-operation: LATENCY=3, antecedent at cycle 0, rst high at cycle 2 -> no consequent at cycle 3; pending=0 and overflow=0 after the reset cycle; antecedent at cycle 4 -> consequent at cycle 7.
